// File: rtl/apb_req_pkg.sv
// Shared types and widths for the APB request queue.
package apb_req_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [DATA_W-1:0] wdata;
    } apb_req_t;

endpackage

// File: rtl/apb_req_queue_if.sv
// Host request/response and APB-master request signals of the request queue.
interface apb_req_queue_if;
    import apb_req_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wr;
    logic [DATA_W-1:0] req_wdata;

    logic              apb_sel;
    logic [ADDR_W-1:0] apb_addr;
    logic              apb_wr;
    logic [DATA_W-1:0] apb_wdata;
    logic              apb_ready;
    logic [DATA_W-1:0] apb_rdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_wr;
    logic              rsp_err;

    modport slave (
        input  req_valid, req_addr, req_wr, req_wdata,
        output req_ready,
        output apb_sel, apb_addr, apb_wr, apb_wdata,
        input  apb_ready, apb_rdata,
        output rsp_valid, rsp_rdata, rsp_wr, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_addr, req_wr, req_wdata,
        input  req_ready,
        input  apb_sel, apb_addr, apb_wr, apb_wdata,
        output apb_ready, apb_rdata,
        input  rsp_valid, rsp_rdata, rsp_wr, rsp_err,
        output rsp_ready
    );

endinterface

// File: rtl/apb_req_fifo.sv
// Synchronous FIFO of apb_req_t; pointers carry an extra wrap bit for full/empty.
module apb_req_fifo
    import apb_req_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_push,
    input  apb_req_t i_data,
    input  logic     i_pop,
    output logic     o_full,
    output logic     o_empty,
    output apb_req_t o_head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    apb_req_t      r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PW'(1);
            if (i_pop)  r_rptr <= r_rptr + PW'(1);
        end
    end

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign o_head  = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/apb_req_queue.sv
// Buffers host requests and issues them one at a time to the APB master, with a
// per-transfer timeout and a registered response back to the host.
module apb_req_queue
    import apb_req_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    apb_req_queue_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_apb_sel;
    logic [ADDR_W-1:0] r_apb_addr;
    logic              r_apb_wr;
    logic [DATA_W-1:0] r_apb_wdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_wr;
    logic              r_rsp_err;

    logic     w_full;
    logic     w_empty;
    logic     w_push;
    logic     w_pop;
    apb_req_t w_head;
    apb_req_t w_req;

    assign w_req  = '{addr: bus.req_addr, wr: bus.req_wr, wdata: bus.req_wdata};
    assign w_push = bus.req_valid && !w_full;
    assign w_pop  = (r_state == IDLE) && !w_empty;

    apb_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_req),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_apb_sel   <= 1'b0;
            r_apb_addr  <= '0;
            r_apb_wr    <= 1'b0;
            r_apb_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_wr    <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_apb_addr  <= w_head.addr;
                        r_apb_wr    <= w_head.wr;
                        r_apb_wdata <= w_head.wdata;
                        r_apb_sel   <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Completion takes priority over a timeout in the same cycle.
                    if (bus.apb_ready) begin
                        r_rsp_rdata <= r_apb_wr ? '0 : bus.apb_rdata;
                        r_rsp_err   <= 1'b0;
                        r_rsp_wr    <= r_apb_wr;
                        r_apb_sel   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_wr    <= r_apb_wr;
                        r_apb_sel   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = !w_full;
    assign bus.apb_sel   = r_apb_sel;
    assign bus.apb_addr  = r_apb_addr;
    assign bus.apb_wr    = r_apb_wr;
    assign bus.apb_wdata = r_apb_wdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_wr    = r_rsp_wr;
    assign bus.rsp_err   = r_rsp_err;

endmodule

// File: doc/apb_req_queue.md
Name: apb_req_queue

Overview:
Upstream command stage for the APB master. It buffers host read/write requests in a small FIFO and issues them one at a time to the master's request inputs (address, write flag, select, write data). It holds each request stable until the transfer completes, then returns a response (read data, error) to the host. A per-transfer timeout prevents a hung slave from stalling the queue.

Parameters:
DEPTH, 4, FIFO entries; power of 2, at least 2
TIMEOUT, 16, maximum cycles in ISSUE before the transfer is aborted with an error; at least 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  host request valid
req_ready  output  1  queue can accept a request (FIFO not full)
req_addr  input  8  request address
req_wr  input  1  1 = write, 0 = read
req_wdata  input  32  write data
apb_sel  output  1  request valid to master; held high for the whole transfer
apb_addr  output  8  address to master
apb_wr  output  1  write/read to master
apb_wdata  output  32  write data to master
apb_ready  input  1  transfer-complete strobe from the APB side (PREADY in the access phase)
apb_rdata  input  32  read data, valid when apb_ready=1
rsp_valid  output  1  response valid
rsp_ready  input  1  host accepts response
rsp_rdata  output  32  captured read data; 0 for writes and errors
rsp_wr  output  1  write flag echoed from the request
rsp_err  output  1  transfer timed out

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO is emptied (pointers = 0) and the state goes to IDLE.
  - apb_sel=0. apb_addr, apb_wr, apb_wdata = 0.
  - rsp_valid=0. rsp_rdata, rsp_wr, rsp_err = 0.
  - Timeout counter = 0.
  - req_ready is 1 one cycle after rst deasserts (FIFO empty).
  - A reset in the middle of a transfer drops apb_sel immediately. The in-flight request and all queued requests are discarded, and no response is produced.
- FIFO:
  - Pointers carry one extra wrap bit. full = indices equal and wrap bits differ; empty = pointers equal.
  - Push when req_valid && req_ready. req_ready = !full, taken from registered state only, so a push into a full FIFO cannot happen.
  - Pop happens only on the IDLE->ISSUE transition. Push and pop in the same cycle are both honoured.
- FSM states: IDLE, ISSUE, RESP. All outputs are registered.
  - IDLE: if !empty, load the head entry into the apb_* registers, pop, set apb_sel=1, clear the counter, and go to ISSUE.
    - Latency: a request pushed at edge N into an empty FIFO in IDLE is seen in the FIFO at N+1. apb_sel=1 is then visible after edge N+2.
  - ISSUE: apb_addr, apb_wr and apb_wdata are held constant. The counter increments every cycle.
    - If apb_ready=1: set rsp_rdata = apb_wr ? 0 : apb_rdata, rsp_err=0, rsp_wr=apb_wr, apb_sel=0, rsp_valid=1, and go to RESP.
    - Else if the counter reaches TIMEOUT-1: set rsp_err=1, rsp_rdata=0, apb_sel=0, rsp_valid=1, and go to RESP.
    - If apb_ready arrives in the same cycle as the timeout, apb_ready wins (normal completion).
  - RESP: rsp_valid is held and the rsp_* fields stay stable until rsp_ready=1. Then rsp_valid=0 and the state returns to IDLE.
    - There is always at least one IDLE cycle between transfers, so apb_sel drops between back-to-back requests.
  - apb_ready is ignored outside ISSUE.
- The counter width is clog2(TIMEOUT). It never wraps, because it is cleared on entry to ISSUE.

Decomposition:
- Package apb_req_pkg holds:
  - state_t enum {IDLE, ISSUE, RESP}.
  - apb_req_t packed struct {addr[7:0], wr, wdata[31:0]}.
  - Width constants ADDR_W=8 and DATA_W=32.
- One sub-module, apb_req_fifo: a parameterised synchronous FIFO of apb_req_t with push, pop, full, empty and head outputs and the same asynchronous active-low reset.

Test Plan:
- Single write: push addr=0x10, wr=1, wdata=0xDEADBEEF; apb_ready pulses 2 cycles after apb_sel rises -> apb_sel is high 3 cycles; response wr=1, err=0, rdata=0.
- Single read: push addr=0x24, wr=0; apb_ready=1 with apb_rdata=0xCAFEF00D -> rsp_rdata=0xCAFEF00D, rsp_err=0; apb_sel drops the cycle after apb_ready.
- Backpressure, DEPTH=4: push 6 requests back-to-back while apb_ready=0 -> req_ready falls after 5 accepts (1 in flight + 4 queued). Release apb_ready -> responses come out in push order with matching addresses.
- Timeout: apb_ready never asserted -> apb_sel is high exactly 16 cycles; rsp_err=1, rsp_rdata=0; the next queued request then issues normally.
- Response stall: rsp_ready=0 for 10 cycles -> rsp_* fields stay stable, apb_sel stays 0, the next request is not issued; it issues 2 cycles after rsp_ready=1.
- Reset mid-transfer: assert rst=0 while in ISSUE with 2 entries queued -> apb_sel=0 immediately and no rsp_valid. After release, req_ready=1, the FIFO is empty, and no stale transfer issues.
